magnitude_bank_arbiter: RTL and testbench
=========================================

MAGNITUDE_BANK_ARBITER -- requirements
Module: magnitude_bank_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 24, giving the magnitude word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 9, giving the bin address width (512 bins).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port i_mag_valid, input, 1 bit: magnitude write strobe from the FFT core.
REQ-006 The block SHALL have port i_mag_addr, input, ADDR_WIDTH bits: bin index of the magnitude being written.
REQ-007 The block SHALL have port i_mag_data, input, DATA_WIDTH bits: magnitude value.
REQ-008 The block SHALL have port i_frame_done, input, 1 bit: one-cycle pulse marking that a frame is complete.
REQ-009 The block SHALL have port i_hold, input, 1 bit: a reader's request to freeze the read bank.
REQ-010 The block SHALL have port i_req, input, 2 bits: read request, one bit per requester (0 = display, 1 = dump).
REQ-011 The block SHALL have ports i_req_addr0 and i_req_addr1, input, ADDR_WIDTH bits each: per-requester read address.
REQ-012 The block SHALL have port o_gnt, output, 2 bits: one-hot grant, combinational, asserted in the acceptance cycle.
REQ-013 The block SHALL have port o_rd_valid, output, 2 bits: one-hot read-data valid, one cycle after grant.
REQ-014 The block SHALL have port o_rd_data, output, DATA_WIDTH bits: read data, qualified by o_rd_valid.
REQ-015 The block SHALL have port o_read_bank, output, 1 bit: the bank currently exposed to readers.
REQ-016 The block SHALL have port o_new_frame, output, 1 bit: one-cycle pulse on each bank swap.
REQ-017 The block SHALL have port o_frame_count, output, 8 bits: number of swaps, wrapping.
REQ-018 The block SHALL have port o_drop_count, output, 8 bits: number of dropped frames, saturating at 255.

Function
REQ-019 The block SHALL contain two banks of 2^ADDR_WIDTH x DATA_WIDTH storage; the write bank is always ~o_read_bank.
REQ-020 When i_mag_valid=1, the block SHALL write i_mag_data to the write bank at i_mag_addr.
REQ-021 Writes SHALL never target the read bank, so no read/write collision exists.
REQ-022 The swap FSM SHALL have states IDLE and PENDING; i_frame_done moves IDLE->PENDING.
REQ-023 In PENDING with i_hold=0, the block SHALL toggle o_read_bank at the next edge, pulse o_new_frame, increment o_frame_count and return to IDLE.
REQ-024 In PENDING with i_hold=1, the block SHALL stay in PENDING with no swap.
REQ-025 If i_frame_done arrives while in PENDING, the block SHALL stay in PENDING and increment o_drop_count (saturating).
REQ-026 If i_frame_done arrives in the same cycle a swap completes, the block SHALL re-enter PENDING with no drop counted.
REQ-027 Arbitration SHALL grant at most one request per cycle.
REQ-028 Arbitration SHALL be round-robin: priority goes to the requester not granted most recently; after reset, requester 0 has priority.
REQ-029 A lone request SHALL be granted in the same cycle it is raised.
REQ-030 A requester SHALL hold i_req and its address until it sees its o_gnt bit.
REQ-031 The granted address and the bank select SHALL be registered on the grant edge; o_rd_data and o_rd_valid SHALL follow one cycle later (latency 1).
REQ-032 A read granted in the swap cycle SHALL return data from the pre-swap bank.
REQ-033 Back-to-back grants SHALL give full throughput: one read per cycle.
REQ-034 o_rd_data SHALL hold its last value when o_rd_valid=0.

Reset
REQ-035 While reset=1, the block SHALL force o_gnt=0, o_rd_valid=0, o_rd_data=0, o_read_bank=0, o_new_frame=0, o_frame_count=0, o_drop_count=0, FSM=IDLE and RR priority=requester 0.
REQ-036 Bank contents SHALL NOT be cleared by reset.
REQ-037 Reset asserted mid-read or mid-PENDING SHALL abort that operation: the pending swap is discarded and no o_rd_valid is issued.

Verification
REQ-038 Write bin 5=0x00ABCD, pulse i_frame_done, then read addr 5 via req0 -> o_new_frame 1 cycle after done, o_read_bank=1, o_rd_data=0x00ABCD with o_rd_valid=01 one cycle after gnt.
REQ-039 i_req=11 held for 4 cycles after reset -> o_gnt sequence 01,10,01,10; o_rd_valid follows with 1-cycle lag.
REQ-040 i_hold=1, then two i_frame_done pulses -> no swap, o_drop_count=1; release hold -> single swap, o_frame_count=1.
REQ-041 Read granted in the swap cycle -> returns old-bank data; next read returns new-bank data.
REQ-042 256 swaps -> o_frame_count wraps to 0; 300 drops -> o_drop_count=255.
REQ-043 Assert reset during PENDING with i_req=01 -> all outputs 0, no swap, no o_rd_valid afterward; bank data still readable.

Source files
------------

// File: rtl/magnitude_bank_arbiter.sv
// Double-buffered magnitude store with a two-requester round-robin read port.
// The FFT core fills the write bank while readers see the other bank; a frame
// completion swaps them, optionally held off by a reader's hold request.
module magnitude_bank_arbiter #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_mag_valid,
    input  logic [ADDR_WIDTH-1:0] i_mag_addr,
    input  logic [DATA_WIDTH-1:0] i_mag_data,
    input  logic                  i_frame_done,
    input  logic                  i_hold,
    input  logic [1:0]            i_req,
    input  logic [ADDR_WIDTH-1:0] i_req_addr0,
    input  logic [ADDR_WIDTH-1:0] i_req_addr1,
    output logic [1:0]            o_gnt,
    output logic [1:0]            o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_read_bank,
    output logic                  o_new_frame,
    output logic [7:0]            o_frame_count,
    output logic [7:0]            o_drop_count
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        IDLE,
        PENDING
    } swap_state_t;

    swap_state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] bank_mem [2][DEPTH];

    logic                  read_bank_q;
    logic                  write_bank;
    logic                  swap;
    logic                  drop;
    logic [7:0]            frame_count_q;
    logic [7:0]            drop_count_q;
    logic                  prio_q;
    logic [1:0]            gnt;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [1:0]            rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    assign write_bank = ~read_bank_q;

    // Magnitude writes always land in the bank readers cannot see.
    always_ff @(posedge clk) begin
        if (i_mag_valid) begin
            bank_mem[write_bank][i_mag_addr] <= i_mag_data;
        end
    end

    // Swap FSM next state: a swap completing with a fresh frame_done re-arms
    // PENDING instead of counting a drop.
    always_comb begin
        state_d = state_q;
        swap    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_frame_done) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (!i_hold) begin
                    swap    = 1'b1;
                    state_d = i_frame_done ? PENDING : IDLE;
                end else if (i_frame_done) begin
                    drop = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Swap FSM state, bank select and frame/drop counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            read_bank_q   <= 1'b0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (swap) begin
                read_bank_q   <= ~read_bank_q;
                frame_count_q <= frame_count_q + 8'd1;
            end
            if (drop && (drop_count_q != 8'hFF)) begin
                drop_count_q <= drop_count_q + 8'd1;
            end
        end
    end

    // Round-robin grant; prio_q names the requester that wins a tie.
    always_comb begin
        gnt = '0;
        if (!reset) begin
            case (i_req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
                default: gnt = '0;
            endcase
        end
    end

    assign rd_addr = gnt[1] ? i_req_addr1 : i_req_addr0;

    // Read port: the bank is sampled at the grant edge, so a read granted in
    // the swap cycle still sees the pre-swap bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            prio_q     <= 1'b0;
        end else begin
            rd_valid_q <= gnt;
            if (|gnt) begin
                rd_data_q <= bank_mem[read_bank_q][rd_addr];
                prio_q    <= gnt[0];
            end
        end
    end

    assign o_gnt         = gnt;
    assign o_rd_valid    = rd_valid_q;
    assign o_rd_data     = rd_data_q;
    assign o_read_bank   = read_bank_q;
    assign o_new_frame   = swap;
    assign o_frame_count = frame_count_q;
    assign o_drop_count  = drop_count_q;

endmodule

// File: tb/tb_magnitude_bank_arbiter.sv
// Bench for magnitude_bank_arbiter: directed scenarios followed by random
// traffic, all compared against a behavioural model of banks, swaps and reads.
module tb_magnitude_bank_arbiter;

    localparam int DW    = 24;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic          mag_valid;
    logic [AW-1:0] mag_addr;
    logic [DW-1:0] mag_data;
    logic          frame_done;
    logic          hold;
    logic [1:0]    req;
    logic [AW-1:0] req_addr0;
    logic [AW-1:0] req_addr1;
    logic [1:0]    o_gnt;
    logic [1:0]    o_rd_valid;
    logic [DW-1:0] o_rd_data;
    logic          o_read_bank;
    logic          o_new_frame;
    logic [7:0]    o_frame_count;
    logic [7:0]    o_drop_count;

    always #5 clk = ~clk;

    magnitude_bank_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_mag_valid  (mag_valid),
        .i_mag_addr   (mag_addr),
        .i_mag_data   (mag_data),
        .i_frame_done (frame_done),
        .i_hold       (hold),
        .i_req        (req),
        .i_req_addr0  (req_addr0),
        .i_req_addr1  (req_addr1),
        .o_gnt        (o_gnt),
        .o_rd_valid   (o_rd_valid),
        .o_rd_data    (o_rd_data),
        .o_read_bank  (o_read_bank),
        .o_new_frame  (o_new_frame),
        .o_frame_count(o_frame_count),
        .o_drop_count (o_drop_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: two banks with knowledge flags, a pending-swap flag,
    // plain integer counters and the identity of the last granted requester.
    logic [DW-1:0] m_mem   [2][DEPTH];
    bit            m_known [2][DEPTH];
    bit            m_rb;
    bit            m_pending;
    int            m_frames;
    int            m_drops;
    int            m_last;
    logic [1:0]    m_valid;
    logic [DW-1:0] m_data;
    bit            m_data_known;
    logic [1:0]    last_gnt;
    logic [1:0]    obs_gnt;

    task automatic model_reset();
        m_rb         = 1'b0;
        m_pending    = 1'b0;
        m_frames     = 0;
        m_drops      = 0;
        m_last       = 1;
        m_valid      = 2'b00;
        m_data       = '0;
        m_data_known = 1'b1;
    endtask

    function automatic logic [1:0] model_grant();
        if (reset) return 2'b00;
        if (req == 2'b11) return (m_last == 0) ? 2'b10 : 2'b01;
        return req;
    endfunction

    // One clock: check combinational outputs before the edge, advance the
    // model at the edge, then check registered outputs just after it.
    task automatic cycle();
        logic [1:0]    eg;
        bit            enf;
        logic [AW-1:0] ra;
        int            w;
        #1;
        if (reset) model_reset();
        eg  = model_grant();
        enf = !reset && m_pending && !hold;
        obs_gnt = o_gnt;
        check_eq("gnt", {30'd0, o_gnt}, {30'd0, eg});
        check_eq("new_frame", {31'd0, o_new_frame}, {31'd0, enf});
        @(posedge clk);
        if (!reset) begin
            if (eg != 2'b00) begin
                w  = eg[1] ? 1 : 0;
                ra = (w == 1) ? req_addr1 : req_addr0;
                m_data       = m_mem[m_rb][ra];
                m_data_known = m_known[m_rb][ra];
                m_last       = w;
            end
            m_valid = eg;
            if (mag_valid) begin
                m_mem[!m_rb][mag_addr]   = mag_data;
                m_known[!m_rb][mag_addr] = 1'b1;
            end
            if (m_pending) begin
                if (!hold) begin
                    m_rb      = !m_rb;
                    m_frames++;
                    m_pending = frame_done;
                end else if (frame_done) begin
                    m_drops++;
                end
            end else begin
                m_pending = frame_done;
            end
        end
        #1;
        check_eq("read_bank", {31'd0, o_read_bank}, {31'd0, m_rb});
        check_eq("frame_count", {24'd0, o_frame_count}, m_frames % 256);
        check_eq("drop_count", {24'd0, o_drop_count}, (m_drops > 255) ? 255 : m_drops);
        check_eq("rd_valid", {30'd0, o_rd_valid}, {30'd0, m_valid});
        if (m_data_known) check_eq("rd_data", {8'd0, o_rd_data}, {8'd0, m_data});
        last_gnt = eg;
    endtask

    task automatic idle_inputs();
        mag_valid  = 1'b0;
        mag_addr   = '0;
        mag_data   = '0;
        frame_done = 1'b0;
        hold       = 1'b0;
        req        = 2'b00;
        req_addr0  = '0;
        req_addr1  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    logic [1:0] rr_exp [4];

    initial begin
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++) begin
                m_known[b][a] = 1'b0;
                m_mem[b][a]   = '0;
            end
        model_reset();
        last_gnt = 2'b00;
        reset    = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;

        // Reset state with a request pending: grant must stay low.
        req = 2'b01;
        cycle();
        check_eq("rst_gnt", {30'd0, obs_gnt}, 32'd0);
        check_eq("rst_rd_data", {8'd0, o_rd_data}, 32'd0);
        reset = 1'b0;
        req   = 2'b00;
        cycle();

        // Write bin 5, finish the frame, read it back through requester 0.
        mag_valid = 1'b1; mag_addr = 9'd5; mag_data = 24'h00ABCD; frame_done = 1'b1;
        cycle();
        mag_valid = 1'b0; frame_done = 1'b0;
        cycle();
        check_eq("bank_after_swap", {31'd0, o_read_bank}, 32'd1);
        req = 2'b01; req_addr0 = 9'd5;
        cycle();
        check_eq("rd_valid_038", {30'd0, o_rd_valid}, 32'd1);
        check_eq("rd_data_038", {8'd0, o_rd_data}, 32'h00ABCD);
        req = 2'b00;
        cycle();
        check_eq("rd_hold", {8'd0, o_rd_data}, 32'h00ABCD);

        // Both requesters held: grants alternate starting with requester 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req = 2'b11; req_addr0 = 9'd1; req_addr1 = 9'd2;
            cycle();
            check_eq("rr_seq", {30'd0, obs_gnt}, {30'd0, rr_exp[i]});
        end
        req = 2'b00;
        cycle();

        // Hold blocks the swap; the second frame_done is dropped.
        hold = 1'b1; frame_done = 1'b1; cycle();
        frame_done = 1'b0; cycle();
        frame_done = 1'b1; cycle();
        frame_done = 1'b0; cycle();
        check_eq("hold_drop", {24'd0, o_drop_count}, 32'd1);
        check_eq("hold_bank", {31'd0, o_read_bank}, 32'd0);
        hold = 1'b0; cycle();
        cycle();
        check_eq("hold_frames", {24'd0, o_frame_count}, 32'd1);

        // Read in the swap cycle returns old-bank data, the next read new data.
        mag_valid = 1'b1; mag_addr = 9'd7; mag_data = 24'h111111; frame_done = 1'b1;
        cycle();
        mag_valid = 1'b0; frame_done = 1'b0;
        cycle();
        mag_valid = 1'b1; mag_addr = 9'd7; mag_data = 24'h222222;
        cycle();
        mag_valid = 1'b0; frame_done = 1'b1;
        cycle();
        frame_done = 1'b0; req = 2'b01; req_addr0 = 9'd7;
        cycle();
        check_eq("swap_old_data", {8'd0, o_rd_data}, 32'h111111);
        cycle();
        check_eq("swap_new_data", {8'd0, o_rd_data}, 32'h222222);
        req = 2'b00;
        cycle();

        // Frame counter wraps after 256 swaps; drop counter saturates.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            frame_done = 1'b1; cycle();
            frame_done = 1'b0; cycle();
        end
        check_eq("frame_wrap", {24'd0, o_frame_count}, 32'd0);
        hold = 1'b1; frame_done = 1'b1;
        for (int i = 0; i < 301; i++) cycle();
        check_eq("drop_sat", {24'd0, o_drop_count}, 32'd255);

        // Reset during PENDING and mid-read aborts both; banks survive.
        do_reset();
        hold = 1'b1; frame_done = 1'b1; cycle();
        frame_done = 1'b0; req = 2'b01; req_addr0 = 9'd5;
        cycle();
        reset = 1'b1; req = 2'b01;
        cycle();
        check_eq("rst_valid", {30'd0, o_rd_valid}, 32'd0);
        check_eq("rst_bank", {31'd0, o_read_bank}, 32'd0);
        reset = 1'b0; hold = 1'b0; req = 2'b00;
        cycle();
        cycle();
        check_eq("no_swap_after_rst", {31'd0, o_read_bank}, 32'd0);
        frame_done = 1'b1; cycle();
        frame_done = 1'b0; cycle();
        req = 2'b01; req_addr0 = 9'd5; cycle();
        check_eq("bank_kept", {8'd0, o_rd_data}, 32'h00ABCD);
        req = 2'b00;
        cycle();

        // Random traffic; requesters keep request and address until granted.
        for (int i = 0; i < 3000; i++) begin
            req = req & ~last_gnt;
            reset = ($urandom_range(0, 199) == 0);
            mag_valid  = !reset && ($urandom_range(0, 1) == 1);
            mag_addr   = AW'($urandom_range(0, 15));
            mag_data   = DW'($urandom);
            frame_done = ($urandom_range(0, 7) == 0);
            hold       = ($urandom_range(0, 2) == 0);
            if (!req[0] && ($urandom_range(0, 1) == 1)) begin
                req[0] = 1'b1; req_addr0 = AW'($urandom_range(0, 15));
            end
            if (!req[1] && ($urandom_range(0, 1) == 1)) begin
                req[1] = 1'b1; req_addr1 = AW'($urandom_range(0, 15));
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
